// File: rtl/multicycle_control.sv
// Sequencer for the multi-cycle MIPS datapath: walks each instruction through
// IF/ID/EX/MEM/WB, decodes datapath enables and selects, and counts retirements.
//   state | meaning
//   IF    | fetch from PC, wait for MemReady, latch IR, PC += 4
//   ID    | register read, branch target into ALUOut, j/jal finish here
//   EX    | ALU op, branch/jr/jalr resolve here
//   MEM   | lw/sw data access at ALUOut, wait for MemReady
//   WB    | register file write
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Funct,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        BranchNe,
    output logic [1:0]  PCSource,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        ExtOp,
    output logic        LuOp,
    output logic [2:0]  State,
    output logic [31:0] Retired
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] retired_q;

    logic is_r, is_shift, is_jr, is_jalr, is_branch, is_lw, is_sw, is_imm, is_known;

    always_comb begin
        is_r      = (OpCode == OP_R);
        is_shift  = is_r && ((Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA));
        is_jr     = is_r && (Funct == FN_JR);
        is_jalr   = is_r && (Funct == FN_JALR);
        is_branch = (OpCode == OP_BEQ) || (OpCode == OP_BNE);
        is_lw     = (OpCode == OP_LW);
        is_sw     = (OpCode == OP_SW);
        is_imm    = (OpCode == OP_ADDI) || (OpCode == OP_ADDIU) || (OpCode == OP_SLTI) ||
                    (OpCode == OP_SLTIU) || (OpCode == OP_ANDI) || (OpCode == OP_LUI);
        is_known  = is_r || is_branch || is_lw || is_sw || is_imm;
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = MemReady ? S_ID : S_IF;
            S_ID:  state_d = is_known ? S_EX : S_IF;
            S_EX: begin
                if (is_r)
                    state_d = (is_jr || is_jalr) ? S_IF : S_WB;
                else if (is_lw || is_sw)
                    state_d = S_MEM;
                else if (is_imm)
                    state_d = S_WB;
                else
                    state_d = S_IF;
            end
            S_MEM: begin
                if (is_lw)
                    state_d = MemReady ? S_WB : S_MEM;
                else if (is_sw)
                    state_d = MemReady ? S_IF : S_MEM;
                else
                    state_d = S_IF;
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // An instruction retires on the edge that brings the sequencer back to IF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IF;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if ((state_q != S_IF) && (state_d == S_IF))
                retired_q <= retired_q + 32'd1;
        end
    end

    assign State   = state_q;
    assign Retired = retired_q;

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        ExtOp       = (OpCode != OP_ANDI);
        LuOp        = (OpCode == OP_LUI);
        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                if ((OpCode == OP_J) || (OpCode == OP_JAL)) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                if (OpCode == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
            end
            S_EX: begin
                if (is_r) begin
                    ALUSrcA = is_shift ? 2'b10 : 2'b01;
                    ALUOp   = 2'b10;
                    if (is_jr || is_jalr) begin
                        PCWrite  = 1'b1;
                        PCSource = 2'b11;
                    end
                    if (is_jalr) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b01;
                        MemtoReg = 2'b10;
                    end
                end else if (is_branch) begin
                    ALUSrcA     = 2'b01;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    BranchNe    = (OpCode == OP_BNE);
                end else if (is_lw || is_sw) begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                end else if (is_imm) begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    ALUOp   = 2'b11;
                end
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = is_lw;
                MemWrite = is_sw;
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = is_r ? 2'b01 : 2'b00;
                MemtoReg = is_lw ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
        // Reset holds every enable and select low, aborting any access in flight.
        if (!reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            BranchNe    = 1'b0;
            PCSource    = 2'b00;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 2'b00;
            MemtoReg    = 2'b00;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            ExtOp       = 1'b0;
            LuOp        = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-class model predicts
// every cycle's controls and retire count; directed literals pin the model.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  OpCode = 6'h00;
    logic [5:0]  Funct = 6'h00;
    logic        MemReady = 1'b0;
    logic        PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0]  PCSource, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp;
    logic        ExtOp, LuOp;
    logic [2:0]  State;
    logic [31:0] Retired;

    multicycle_control dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtOp(ExtOp), .LuOp(LuOp),
        .State(State), .Retired(Retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, bne;
        logic [1:0] pcsrc;
        logic       iord, mrd, mwr, irw, rgw;
        logic [1:0] rdst, m2r, srca, srcb, aluop;
        logic       ext, lu;
        logic [2:0] st;
    } ctl_t;

    typedef enum int {C_J, C_JAL, C_BR, C_JR, C_JALR, C_SHIFT, C_RALU, C_IALU, C_LW, C_SW, C_UNK} cls_t;

    localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4;

    ctl_t        dut_vec, exp_vec, snap;
    logic [31:0] exp_ret, ret_model;
    logic        chk_en = 1'b0;
    int          n_tests = 0, n_fail = 0;
    int          cnt_cyc, cnt_pcw, cnt_irw, cnt_rd_alu, cnt_regw, cnt_memwr;

    assign dut_vec = {PCWrite, PCWriteCond, BranchNe, PCSource, IorD, MemRead, MemWrite, IRWrite,
                      RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ExtOp, LuOp, State};

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h08) return C_JR;
                if (fn == 6'h09) return C_JALR;
                if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) return C_SHIFT;
                return C_RALU;
            end
            6'h02: return C_J;
            6'h03: return C_JAL;
            6'h04, 6'h05: return C_BR;
            6'h23: return C_LW;
            6'h2b: return C_SW;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: return C_IALU;
            default: return C_UNK;
        endcase
    endfunction

    // What the datapath must see for an instruction class in a given phase.
    function automatic ctl_t expect_ctl(input cls_t c, input int ph, input logic [5:0] op, input logic rdy);
        ctl_t e;
        e     = '0;
        e.st  = 3'(ph);
        e.ext = (op != 6'h0c);
        e.lu  = (op == 6'h0f);
        if (ph == P_IF) begin
            e.mrd = 1'b1; e.srcb = 2'd1; e.irw = rdy; e.pcw = rdy;
        end else if (ph == P_ID) begin
            e.srcb = 2'd3;
            if (c == C_J || c == C_JAL) begin e.pcw = 1'b1; e.pcsrc = 2'd2; end
            if (c == C_JAL) begin e.rgw = 1'b1; e.rdst = 2'd2; e.m2r = 2'd2; end
        end else if (ph == P_EX) begin
            case (c)
                C_SHIFT: begin e.srca = 2'd2; e.aluop = 2'd2; end
                C_RALU:  begin e.srca = 2'd1; e.aluop = 2'd2; end
                C_JR:    begin e.srca = 2'd1; e.aluop = 2'd2; e.pcw = 1'b1; e.pcsrc = 2'd3; end
                C_JALR:  begin e.srca = 2'd1; e.aluop = 2'd2; e.pcw = 1'b1; e.pcsrc = 2'd3;
                               e.rgw = 1'b1; e.rdst = 2'd1; e.m2r = 2'd2; end
                C_BR:    begin e.srca = 2'd1; e.aluop = 2'd1; e.pcwc = 1'b1; e.pcsrc = 2'd1;
                               e.bne = (op == 6'h05); end
                C_LW, C_SW: begin e.srca = 2'd1; e.srcb = 2'd2; end
                C_IALU:  begin e.srca = 2'd1; e.srcb = 2'd2; e.aluop = 2'd3; end
                default: ;
            endcase
        end else if (ph == P_MEM) begin
            e.iord = 1'b1; e.mrd = (c == C_LW); e.mwr = (c == C_SW);
        end else begin
            e.rgw  = 1'b1;
            e.rdst = (c == C_RALU || c == C_SHIFT) ? 2'd1 : 2'd0;
            e.m2r  = (c == C_LW) ? 2'd1 : 2'd0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests += 2;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL ctl t=%0t got %h want %h", $time, dut_vec, exp_vec);
            end
            if (Retired !== exp_ret) begin
                n_fail++;
                $display("FAIL retired t=%0t got %h want %h", $time, Retired, exp_ret);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Called and returns at posedge+1; stop_after>0 abandons the instruction early.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int if_stall,
                             input int mem_stall, input int stop_after, input int snap_ph);
        cls_t c;
        int   path[$];
        logic rdy[$];
        int   limit;
        bit   snapped;
        c = classify(op, fn);
        for (int k = 0; k < if_stall; k++) begin path.push_back(P_IF); rdy.push_back(1'b0); end
        path.push_back(P_IF); rdy.push_back(1'b1);
        path.push_back(P_ID); rdy.push_back(1'($urandom_range(0, 1)));
        if (c != C_J && c != C_JAL && c != C_UNK) begin
            path.push_back(P_EX); rdy.push_back(1'($urandom_range(0, 1)));
        end
        if (c == C_LW || c == C_SW) begin
            for (int k = 0; k < mem_stall; k++) begin path.push_back(P_MEM); rdy.push_back(1'b0); end
            path.push_back(P_MEM); rdy.push_back(1'b1);
        end
        if (c == C_LW || c == C_RALU || c == C_SHIFT || c == C_IALU) begin
            path.push_back(P_WB); rdy.push_back(1'($urandom_range(0, 1)));
        end
        limit = (stop_after > 0) ? stop_after : path.size();
        cnt_cyc = 0; cnt_pcw = 0; cnt_irw = 0; cnt_rd_alu = 0; cnt_regw = 0; cnt_memwr = 0;
        snapped = 1'b0; snap = '0;
        for (int i = 0; i < limit; i++) begin
            OpCode   = op;
            Funct    = fn;
            MemReady = rdy[i];
            exp_vec  = expect_ctl(c, path[i], op, rdy[i]);
            exp_ret  = ret_model;
            chk_en   = 1'b1;
            @(negedge clk);
            cnt_cyc++;
            if (PCWrite)          cnt_pcw++;
            if (IRWrite)          cnt_irw++;
            if (MemRead && IorD)  cnt_rd_alu++;
            if (RegWrite)         cnt_regw++;
            if (MemWrite)         cnt_memwr++;
            if (path[i] == snap_ph && !snapped) begin snap = dut_vec; snapped = 1'b1; end
            @(posedge clk); #1;
        end
        if (limit == path.size()) ret_model = ret_model + 32'd1;
    endtask

    typedef struct { logic [5:0] op; logic [5:0] fn; int ifs; int mems; } vec_t;
    vec_t mix[13];

    initial begin
        ret_model = 32'd0;
        // Reset held with MemReady high: every control must stay low.
        MemReady = 1'b1;
        OpCode   = 6'h03;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            exp_vec = '0;
            exp_ret = 32'd0;
            chk_en  = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
        end
        reset = 1'b1;

        run_instr(6'h00, 6'h20, 0, 0, 0, P_WB);
        check("add_cycles", 64'(cnt_cyc), 64'd4);
        check("add_regwrite_once", 64'(cnt_regw), 64'd1);
        check("add_wb_regdst", 64'(snap.rdst), 64'd1);
        check("add_retired", 64'(Retired), 64'd1);
        check("add_back_in_if", 64'(State), 64'd0);

        run_instr(6'h23, 6'h00, 0, 2, 0, P_WB);
        check("lw_cycles", 64'(cnt_cyc), 64'd7);
        check("lw_memread_iord", 64'(cnt_rd_alu), 64'd3);
        check("lw_regwrite_once", 64'(cnt_regw), 64'd1);
        check("lw_wb_memtoreg", 64'(snap.m2r), 64'd1);

        run_instr(6'h2b, 6'h00, 3, 0, 0, P_MEM);
        check("sw_cycles", 64'(cnt_cyc), 64'd7);
        check("sw_pcwrite_once", 64'(cnt_pcw), 64'd1);
        check("sw_irwrite_once", 64'(cnt_irw), 64'd1);
        check("sw_memwrite_once", 64'(cnt_memwr), 64'd1);
        check("sw_retired", 64'(Retired), 64'd3);

        run_instr(6'h03, 6'h00, 0, 0, 0, P_ID);
        check("jal_cycles", 64'(cnt_cyc), 64'd2);
        check("jal_id_fields", 64'({snap.pcw, snap.pcsrc, snap.rgw, snap.rdst, snap.m2r}), 64'b1_10_1_10_10);

        run_instr(6'h05, 6'h00, 0, 0, 0, P_EX);
        check("bne_cycles", 64'(cnt_cyc), 64'd3);
        check("bne_ex_fields", 64'({snap.pcwc, snap.bne, snap.aluop}), 64'b1_1_01);

        run_instr(6'h00, 6'h00, 0, 0, 0, P_EX);
        check("sll_cycles", 64'(cnt_cyc), 64'd4);
        check("sll_ex_srca", 64'(snap.srca), 64'd2);

        mix[0]  = '{6'h04, 6'h00, 0, 0};
        mix[1]  = '{6'h00, 6'h08, 1, 0};
        mix[2]  = '{6'h00, 6'h09, 0, 0};
        mix[3]  = '{6'h08, 6'h00, 0, 0};
        mix[4]  = '{6'h0c, 6'h00, 2, 0};
        mix[5]  = '{6'h0f, 6'h00, 0, 0};
        mix[6]  = '{6'h3f, 6'h00, 0, 0};
        mix[7]  = '{6'h02, 6'h00, 1, 0};
        mix[8]  = '{6'h00, 6'h02, 0, 0};
        mix[9]  = '{6'h00, 6'h03, 0, 0};
        mix[10] = '{6'h0b, 6'h00, 0, 0};
        mix[11] = '{6'h2b, 6'h00, 0, 1};
        mix[12] = '{6'h23, 6'h00, 1, 0};
        foreach (mix[i]) run_instr(mix[i].op, mix[i].fn, mix[i].ifs, mix[i].mems, 0, P_EX);
        check("mix_retired", 64'(Retired), 64'd19);

        // Preset the counter to all-ones, then one retirement must wrap it.
        chk_en = 1'b0;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        ret_model = 32'hFFFF_FFFF;
        run_instr(6'h02, 6'h00, 0, 0, 0, P_ID);
        check("wrap_retired", 64'(Retired), 64'd0);

        // Abort a store mid-MEM with reset.
        run_instr(6'h2b, 6'h00, 0, 5, 4, P_MEM);
        chk_en = 1'b0;
        check("abort_memwrite_before", 64'(MemWrite), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_memwrite_drop", 64'(MemWrite), 64'd0);
        check("abort_state", 64'(State), 64'd0);
        check("abort_retired", 64'(Retired), 64'd0);
        ret_model = 32'd0;
        @(posedge clk); #1;
        check("abort_no_write_held", 64'({MemWrite, RegWrite, PCWrite}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_instr(6'h00, 6'h20, 0, 0, 0, P_WB);
        check("post_abort_retired", 64'(Retired), 64'd1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
